// File: rtl/alu_seq_if.sv
// Operation/result bundle between the EX-stage issue logic and the sequential ALU.
// The master presents an operation with in_valid and holds it until in_ready.
// The slave returns registered results and the architectural HI/LO registers.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int SAW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [SAW-1:0]   sa;
  logic             out_valid;
  logic [WIDTH-1:0] rd;
  logic             zf;
  logic             of;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, op, rs, rt, sa,
    input  in_ready, out_valid, rd, zf, of, hi, lo
  );

  modport slave (
    input  in_valid, op, rs, rt, sa,
    output in_ready, out_valid, rd, zf, of, hi, lo
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU for the EX stage.
// Single-cycle operations are registered with one cycle of latency.
// Multiply/divide run iteratively, one radix-2 step per cycle, into HI/LO.
// While a multiply/divide is in flight, in_ready is low and the pipeline stalls.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SAW   = 5
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = SAW + 1;

  localparam logic [4:0] OP_AND  = 5'h01;
  localparam logic [4:0] OP_OR   = 5'h02;
  localparam logic [4:0] OP_ADDU = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_NOR  = 5'h05;
  localparam logic [4:0] OP_SUBU = 5'h06;
  localparam logic [4:0] OP_SLT  = 5'h07;
  localparam logic [4:0] OP_SLL  = 5'h08;
  localparam logic [4:0] OP_SRL  = 5'h09;
  localparam logic [4:0] OP_SRA  = 5'h0A;
  localparam logic [4:0] OP_ADD  = 5'h0B;
  localparam logic [4:0] OP_SUB  = 5'h0C;
  localparam logic [4:0] OP_MFHI = 5'h14;
  localparam logic [4:0] OP_MFLO = 5'h15;
  localparam logic [4:0] OP_MTHI = 5'h16;
  localparam logic [4:0] OP_MTLO = 5'h17;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  state_t state, state_next;
  logic   in_ready_c;
  logic   accept;
  logic   is_md;

  logic [WIDTH-1:0] hi_r, lo_r, rd_r;
  logic             zf_r, of_r, out_valid_r;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] work_hi, work_lo, mag_b, rs_save;
  logic             is_div, neg_q, neg_r, div0;

  logic [WIDTH-1:0]   alu_res, sum, diff;
  logic               alu_of;
  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem;

  // Multiply/divide opcodes occupy 0x10..0x13; an operation is taken only in IDLE.
  assign is_md  = (bus.op[4:2] == 3'b100);
  assign accept = in_ready_c & bus.in_valid;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.rd        = rd_r;
  assign bus.zf        = zf_r;
  assign bus.of        = of_r;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;

  // State register for the multiply/divide sequencer.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and ready: only IDLE accepts; BUSY leaves when the last step is taken.
  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && is_md) state_next = BUSY;
      end
      BUSY: begin
        if (count == CW'(1)) state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle result and signed-overflow flag for the presented operation.
  always_comb begin
    sum     = bus.rs + bus.rt;
    diff    = bus.rs - bus.rt;
    alu_res = bus.rt;
    alu_of  = 1'b0;
    case (bus.op)
      OP_AND:  alu_res = bus.rs & bus.rt;
      OP_OR:   alu_res = bus.rs | bus.rt;
      OP_ADDU: alu_res = sum;
      OP_XOR:  alu_res = bus.rs ^ bus.rt;
      OP_NOR:  alu_res = ~(bus.rs | bus.rt);
      OP_SUBU: alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.rs) < $signed(bus.rt))};
      OP_SLL:  alu_res = bus.rs << bus.sa;
      OP_SRL:  alu_res = bus.rs >> bus.sa;
      OP_SRA:  alu_res = $unsigned($signed(bus.rs) >>> bus.sa);
      OP_ADD: begin
        alu_res = sum;
        alu_of  = (bus.rs[MSB] == bus.rt[MSB]) & (sum[MSB] != bus.rs[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = (bus.rs[MSB] != bus.rt[MSB]) & (diff[MSB] != bus.rs[MSB]);
      end
      OP_MFHI: alu_res = hi_r;
      OP_MFLO: alu_res = lo_r;
      OP_MTHI: alu_res = '0;
      OP_MTLO: alu_res = '0;
      default: alu_res = bus.rt;
    endcase
  end

  // Operand magnitudes and sign flags; signed forms are the even opcodes.
  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.rs[MSB];
    b_neg     = op_signed & bus.rt[MSB];
    mag_a_in  = a_neg ? -bus.rs : bus.rs;
    mag_b_in  = b_neg ? -bus.rt : bus.rt;
  end

  // One iteration step and the final sign correction of the iterative unit.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    div_shift = {work_hi, work_lo[MSB]};
    div_diff  = div_shift - {1'b0, mag_b};
    prod      = {work_hi, work_lo};
    prod_fix  = neg_q ? -prod : prod;
    quot      = neg_q ? -work_lo : work_lo;
    rem       = neg_r ? -work_hi : work_hi;
  end

  // Datapath: result registers, HI/LO, and the shift-add / shift-subtract working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r        <= '0;
      lo_r        <= '0;
      rd_r        <= '0;
      zf_r        <= 1'b0;
      of_r        <= 1'b0;
      out_valid_r <= 1'b0;
      count       <= '0;
      work_hi     <= '0;
      work_lo     <= '0;
      mag_b       <= '0;
      rs_save     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div0        <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (accept) begin
        if (is_md) begin
          count   <= CW'(WIDTH);
          work_hi <= '0;
          work_lo <= mag_a_in;
          mag_b   <= mag_b_in;
          rs_save <= bus.rs;
          is_div  <= bus.op[1];
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          div0    <= (bus.rt == '0);
        end else begin
          rd_r        <= alu_res;
          zf_r        <= (alu_res == '0);
          of_r        <= alu_of;
          out_valid_r <= 1'b1;
          if (bus.op == OP_MTHI) hi_r <= bus.rs;
          if (bus.op == OP_MTLO) lo_r <= bus.rs;
        end
      end else if (state == BUSY) begin
        count <= count - CW'(1);
        if (is_div) begin
          if (!div_diff[WIDTH]) begin
            work_hi <= div_diff[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], 1'b1};
          end else begin
            work_hi <= div_shift[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          {work_hi, work_lo} <= {mul_sum, work_lo[WIDTH-1:1]};
        end
      end else if (state == FIX) begin
        if (is_div) begin
          if (div0) begin
            hi_r <= rs_save;
            lo_r <= '1;
          end else begin
            hi_r <= rem;
            lo_r <= quot;
          end
        end else begin
          {hi_r, lo_r} <= prod_fix;
        end
        rd_r        <= '0;
        zf_r        <= 1'b1;
        of_r        <= 1'b0;
        out_valid_r <= 1'b1;
      end
    end
  end

endmodule
